// File: rtl/fpnew_result_buffer.sv
// Result FIFO between an FPU opgroup and its consumer; head entry is driven straight from storage.
// Define FPNEW_RESULT_BUF_STICKY_EN to add sticky exception flags accumulated over all pops.
module fpnew_result_buffer #(
    parameter int unsigned Width    = 32,
    parameter int unsigned Depth    = 4,
    parameter int unsigned TagWidth = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [Width-1:0]           in_result_i,
    input  logic [4:0]                 in_status_i,
    input  logic                       in_ext_bit_i,
    input  logic [TagWidth-1:0]        in_tag_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
    output logic [Width-1:0]           out_result_o,
    output logic [4:0]                 out_status_o,
    output logic                       out_ext_bit_o,
    output logic [TagWidth-1:0]        out_tag_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
`ifdef FPNEW_RESULT_BUF_STICKY_EN
    input  logic                       clr_fflags_i,
    output logic [4:0]                 fflags_o,
`endif
    output logic [$clog2(Depth+1)-1:0] usage_o,
    output logic                       busy_o
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned UsageW = $clog2(Depth + 1);
    localparam int unsigned EntryW = Width + 5 + 1 + TagWidth;
    localparam logic [UsageW-1:0] DepthU = UsageW'(Depth);

    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [UsageW-1:0] usage_q, usage_d;
    logic [EntryW-1:0] mem_q [Depth];
    logic [EntryW-1:0] entry_d;
    logic              push, pop;

    assign in_ready_o  = (usage_q < DepthU);
    assign out_valid_o = (usage_q != '0);
    assign usage_o     = usage_q;
    assign busy_o      = out_valid_o;

    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & out_ready_i & ~flush_i;

    assign entry_d = {in_result_i, in_status_i, in_ext_bit_i, in_tag_i};
    assign {out_result_o, out_status_o, out_ext_bit_o, out_tag_o} = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usage_d  = usage_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usage_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   usage_d = usage_q + UsageW'(1);
                2'b01:   usage_d = usage_q - UsageW'(1);
                default: usage_d = usage_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usage_q  <= usage_d;
        end
    end

    // Storage is data-only, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= entry_d;
    end

`ifdef FPNEW_RESULT_BUF_STICKY_EN
    logic [4:0] fflags_q, fflags_d;

    always_comb begin
        fflags_d = fflags_q;
        if (clr_fflags_i) fflags_d = pop ? out_status_o : 5'b0;
        else if (pop)     fflags_d = fflags_q | out_status_o;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) fflags_q <= 5'b0;
        else         fflags_q <= fflags_d;
    end

    assign fflags_o = fflags_q;
`endif

endmodule

// File: tb/tb_fpnew_result_buffer.sv
// Directed bench for fpnew_result_buffer: vector table plus wrap, and optional sticky-flag sequences.
module tb_fpnew_result_buffer;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] in_result_i;
    logic [4:0]  in_status_i;
    logic        in_ext_bit_i;
    logic [4:0]  in_tag_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        flush_i;
    logic [31:0] out_result_o;
    logic [4:0]  out_status_o;
    logic        out_ext_bit_o;
    logic [4:0]  out_tag_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [2:0]  usage_o;
    logic        busy_o;
`ifdef FPNEW_RESULT_BUF_STICKY_EN
    logic        clr_fflags_i;
    logic [4:0]  fflags_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fpnew_result_buffer #(.Width(32), .Depth(4), .TagWidth(5)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_result_i  (in_result_i),
        .in_status_i  (in_status_i),
        .in_ext_bit_i (in_ext_bit_i),
        .in_tag_i     (in_tag_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .flush_i      (flush_i),
        .out_result_o (out_result_o),
        .out_status_o (out_status_o),
        .out_ext_bit_o(out_ext_bit_o),
        .out_tag_o    (out_tag_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
`ifdef FPNEW_RESULT_BUF_STICKY_EN
        .clr_fflags_i (clr_fflags_i),
        .fflags_o     (fflags_o),
`endif
        .usage_o      (usage_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        iv;
        logic [31:0] ires;
        logic        ordy;
        logic [2:0]  usage;
        logic        ov;
        logic        ir;
        logic [31:0] ores;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic f, input logic i, input logic [31:0] res,
                                input logic o, input logic [2:0] u, input logic ov, input logic ir,
                                input logic [31:0] ores);
        vec_t x;
        x.rst_n = r; x.flush = f; x.iv = i; x.ires = res; x.ordy = o;
        x.usage = u; x.ov = ov; x.ir = ir; x.ores = ores;
        return x;
    endfunction

    // Side fields are derived from the result so every field of an entry is checkable.
    function automatic logic [4:0] stat_of(input logic [31:0] r);
        return r[4:0] ^ 5'h0a;
    endfunction
    function automatic logic ext_of(input logic [31:0] r);
        return ^r;
    endfunction
    function automatic logic [4:0] tag_of(input logic [31:0] r);
        return r[4:0] + 5'd1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] res,
                         input logic [4:0] st, input logic ex, input logic [4:0] tg,
                         input logic o, input logic clr);
        rst_ni = r; flush_i = f; in_valid_i = iv; in_result_i = res;
        in_status_i = st; in_ext_bit_i = ex; in_tag_i = tg; out_ready_i = o;
`ifdef FPNEW_RESULT_BUF_STICKY_EN
        clr_fflags_i = clr;
`else
        if (clr) $display("note: clr_fflags_i ignored in this build");
`endif
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        vecs[0]  = mk(H, L, H, 32'h1, L, 3'd0, L, H, 32'h0);
        vecs[1]  = mk(H, L, H, 32'h2, L, 3'd1, H, H, 32'h1);
        vecs[2]  = mk(H, L, H, 32'h3, L, 3'd2, H, H, 32'h1);
        vecs[3]  = mk(H, L, L, 32'h0, L, 3'd3, H, H, 32'h1);
        vecs[4]  = mk(H, L, L, 32'h0, L, 3'd3, H, H, 32'h1);
        vecs[5]  = mk(H, L, H, 32'h4, L, 3'd3, H, H, 32'h1);
        vecs[6]  = mk(H, L, H, 32'h5, L, 3'd4, H, L, 32'h1);
        vecs[7]  = mk(H, L, H, 32'h5, H, 3'd4, H, L, 32'h1);
        vecs[8]  = mk(H, L, H, 32'h5, L, 3'd3, H, H, 32'h2);
        vecs[9]  = mk(H, L, L, 32'h0, H, 3'd4, H, L, 32'h2);
        vecs[10] = mk(H, L, L, 32'h0, H, 3'd3, H, H, 32'h3);
        vecs[11] = mk(H, L, L, 32'h0, H, 3'd2, H, H, 32'h4);
        vecs[12] = mk(H, L, L, 32'h0, H, 3'd1, H, H, 32'h5);
        vecs[13] = mk(H, L, H, 32'h6, H, 3'd0, L, H, 32'h0);
        vecs[14] = mk(H, L, H, 32'h7, L, 3'd1, H, H, 32'h6);
        vecs[15] = mk(H, L, H, 32'h8, L, 3'd2, H, H, 32'h6);
        vecs[16] = mk(H, H, H, 32'h9, H, 3'd3, H, H, 32'h6);
        vecs[17] = mk(H, L, H, 32'ha, L, 3'd0, L, H, 32'h0);
        vecs[18] = mk(H, L, H, 32'hb, L, 3'd1, H, H, 32'ha);
        vecs[19] = mk(L, L, H, 32'hc, H, 3'd2, H, H, 32'ha);
        vecs[20] = mk(H, L, L, 32'h0, L, 3'd0, L, H, 32'h0);
        vecs[21] = mk(H, L, H, 32'hd, L, 3'd0, L, H, 32'h0);
        vecs[22] = mk(H, L, H, 32'he, H, 3'd1, H, H, 32'hd);
        vecs[23] = mk(H, L, L, 32'h0, H, 3'd1, H, H, 32'he);
        vecs[24] = mk(H, L, L, 32'h0, L, 3'd0, L, H, 32'h0);

        drive(L, L, L, 32'h0, 5'h0, L, 5'h0, L, L);
        tick();
        tick();
        drive(H, L, L, 32'h0, 5'h0, L, 5'h0, L, L);
        chk("reset usage", 32'(usage_o), 32'd0);
        chk("reset out_valid", 32'(out_valid_o), 32'd0);
        chk("reset in_ready", 32'(in_ready_o), 32'd1);
        chk("reset busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst_n, vecs[i].flush, vecs[i].iv, vecs[i].ires, stat_of(vecs[i].ires),
                  ext_of(vecs[i].ires), tag_of(vecs[i].ires), vecs[i].ordy, L);
            chk($sformatf("v%0d usage", i), 32'(usage_o), 32'(vecs[i].usage));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid_o), 32'(vecs[i].ov));
            chk($sformatf("v%0d busy", i), 32'(busy_o), 32'(vecs[i].ov));
            chk($sformatf("v%0d in_ready", i), 32'(in_ready_o), 32'(vecs[i].ir));
            if (vecs[i].ov) begin
                chk($sformatf("v%0d out_result", i), out_result_o, vecs[i].ores);
                chk($sformatf("v%0d out_status", i), 32'(out_status_o), 32'(stat_of(vecs[i].ores)));
                chk($sformatf("v%0d out_ext", i), 32'(out_ext_bit_o), 32'(ext_of(vecs[i].ores)));
                chk($sformatf("v%0d out_tag", i), 32'(out_tag_o), 32'(tag_of(vecs[i].ores)));
            end
            tick();
        end

        // Streaming: one entry in flight, push and pop every cycle, pointers wrap several times.
        drive(H, L, H, 32'h100, 5'd0, L, 5'd0, L, L);
        tick();
        for (int k = 1; k < 20; k++) begin
            drive(H, L, H, 32'h100 + 32'(k), 5'(k), H, 5'(k), H, L);
            chk($sformatf("wrap%0d usage", k), 32'(usage_o), 32'd1);
            chk($sformatf("wrap%0d tag", k), 32'(out_tag_o), 32'(k - 1));
            chk($sformatf("wrap%0d result", k), out_result_o, 32'h100 + 32'(k - 1));
            tick();
        end
        drive(H, L, L, 32'h0, 5'd0, L, 5'd0, H, L);
        chk("wrap last tag", 32'(out_tag_o), 32'd19);
        tick();
        chk("wrap drained usage", 32'(usage_o), 32'd0);

`ifdef FPNEW_RESULT_BUF_STICKY_EN
        drive(H, L, L, 32'h0, 5'b00000, L, 5'd0, L, H);
        tick();
        chk("sticky clear idle", 32'(fflags_o), 32'd0);
        drive(H, L, H, 32'h21, 5'b00001, L, 5'd1, L, L);
        tick();
        drive(H, L, H, 32'h22, 5'b10000, L, 5'd2, H, L);
        tick();
        chk("sticky first pop", 32'(fflags_o), 32'b00001);
        drive(H, L, L, 32'h0, 5'b00000, L, 5'd0, H, L);
        tick();
        chk("sticky accum", 32'(fflags_o), 32'b10001);
        drive(H, H, L, 32'h0, 5'b00000, L, 5'd0, L, L);
        tick();
        chk("sticky vs flush", 32'(fflags_o), 32'b10001);
        drive(H, L, H, 32'h23, 5'b00100, L, 5'd3, L, L);
        tick();
        drive(H, L, L, 32'h0, 5'b00000, L, 5'd0, H, H);
        tick();
        chk("sticky clr with pop", 32'(fflags_o), 32'b00100);
        drive(H, L, L, 32'h0, 5'b00000, L, 5'd0, L, H);
        tick();
        chk("sticky clr alone", 32'(fflags_o), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
